// File: rtl/gate_sweep_ctrl.sv
// Sweep sequencer for a 2-input gate cell: applies {a,b} = 0..3, waits
// SETTLE_CYCLES extra cycles per vector, samples gate_y against a captured truth table.
module gate_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] truth,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [1:0] vec_idx
);

   localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       truth_q;
   logic             sample;
   logic [3:0]       fail_mask_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            if (cnt == CNT_LAST) begin
               sample = 1'b1;
               if (vec_idx == 2'd3) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Mask including the sample taken on this edge, so pass can see the final vector.
   always_comb begin
      fail_mask_nxt = fail_mask;
      if (sample && (gate_y != truth_q[vec_idx])) begin
         fail_mask_nxt[vec_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         truth_q   <= 4'd0;
         fail_mask <= 4'd0;
         pass      <= 1'b0;
         vec_idx   <= 2'd0;
         cnt       <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            truth_q   <= truth;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
            vec_idx   <= 2'd0;
            cnt       <= '0;
         end
      end else if (state == APPLY) begin
         if (sample) begin
            fail_mask <= fail_mask_nxt;
            vec_idx   <= vec_idx + 2'd1;
            cnt       <= '0;
            if (vec_idx == 2'd3) begin
               pass <= (fail_mask_nxt == 4'd0);
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign busy   = (state == APPLY);
   assign done   = (state == DONE);
   assign gate_a = busy & vec_idx[1];
   assign gate_b = busy & vec_idx[0];

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboarded bench for gate_sweep_ctrl: two lanes (SETTLE_CYCLES 2 and 0), each with
// a behavioural gate model, a sweep-level reference model and a per-cycle monitor.
module tb_gate_sweep_ctrl;

   typedef struct {
      int         e0;
      logic [3:0] mask;
   } exp_t;

   localparam logic [3:0] NOR_TT = 4'b0001;
   localparam logic [3:0] AND_TT = 4'b1000;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int g, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL lane%0d %s at cycle %0d: got 0x%0h, expected 0x%0h", g, nm, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int S = (g == 0) ? 2 : 0;
      localparam int RUN = 4 * (S + 1);

      logic       rst_l;
      logic       start_l;
      logic [3:0] truth_l;
      logic       ga, gb, gy;
      logic       busy_l, done_l, pass_l;
      logic [3:0] mask_l;
      logic [1:0] vec_l;
      logic [3:0] mtt = 4'd0;
      int         next_ok = 0;
      logic       fin = 1'b0;
      exp_t       q[$];
      logic [3:0] held_mask = 4'd0;
      logic       held_pass = 1'b0;

      // Gate under test: combinational truth-table model
      assign gy = mtt[{ga, gb}];

      gate_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
         .clk       (clk),
         .rst_n     (rst_l),
         .start     (start_l),
         .truth     (truth_l),
         .gate_a    (ga),
         .gate_b    (gb),
         .gate_y    (gy),
         .busy      (busy_l),
         .done      (done_l),
         .pass      (pass_l),
         .fail_mask (mask_l),
         .vec_idx   (vec_l)
      );

      task automatic cycle(input logic st, input logic [3:0] tr, input logic [3:0] mt);
         exp_t e;
         start_l = st;
         truth_l = tr;
         if (st && rst_l && (cyc + 1 >= next_ok)) begin
            mtt     = mt;
            e.e0    = cyc + 1;
            e.mask  = tr ^ mt;
            q.push_back(e);
            next_ok = cyc + 1 + RUN + 2;
         end
         @(negedge clk);
      endtask

      task automatic idle(input int n);
         repeat (n) cycle(1'b0, 4'($urandom), 4'($urandom));
      endtask

      initial begin
         rst_l   = 1'b0;
         start_l = 1'b0;
         truth_l = 4'd0;
         #3;
         check("reset_outputs", g, {busy_l, done_l, ga, gb, vec_l, pass_l, mask_l}, 0);
         @(negedge clk);
         #2 rst_l = 1'b1;
         // NOR cell, correct table
         cycle(1'b1, NOR_TT, NOR_TT);
         idle(RUN + 3);
         // AND cell checked against NOR table
         cycle(1'b1, NOR_TT, AND_TT);
         idle(RUN + 3);
         // AND cell, correct table
         cycle(1'b1, AND_TT, AND_TT);
         idle(RUN + 3);
         // start held high across several sweeps with changing truth
         repeat (3 * (RUN + 2)) cycle(1'b1, 4'($urandom), 4'($urandom));
         idle(RUN + 3);
         // back-to-back: failing run then passing run at minimum spacing
         cycle(1'b1, NOR_TT, 4'b0011);
         idle(RUN + 1);
         cycle(1'b1, NOR_TT, NOR_TT);
         idle(RUN + 3);
         // reset while vector 2 is applied
         cycle(1'b1, NOR_TT, AND_TT);
         idle(2 * (S + 1));
         check("vec_before_reset", g, vec_l, 2);
         #2 rst_l = 1'b0;
         #1;
         check("outputs_in_reset", g, {busy_l, done_l, ga, gb, vec_l, pass_l, mask_l}, 0);
         q.delete();
         next_ok = 0;
         cycle(1'b0, 4'd0, 4'd0);
         cycle(1'b0, 4'd0, 4'd0);
         #2 rst_l = 1'b1;
         cycle(1'b1, NOR_TT, NOR_TT);
         idle(RUN + 3);
         // random traffic
         repeat (400) cycle(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
         idle(RUN + 3);
         fin = 1'b1;
      end

      // Monitor: derives every output from the pending sweep's start edge and result
      initial begin
         forever begin
            int         t;
            int         v;
            logic [3:0] m;
            logic [10:0] e;
            @(negedge clk);
            if (!rst_l) begin
               held_mask = 4'd0;
               held_pass = 1'b0;
            end else begin
               e = {4'b0000, 2'b00, held_pass, held_mask};
               if (q.size() > 0) begin
                  t = cyc - q[0].e0;
                  if (t >= 0 && t < RUN) begin
                     v = t / (S + 1);
                     m = 4'd0;
                     for (int k = 0; k < 4; k++) begin
                        if ((k + 1) * (S + 1) <= t) m[k] = q[0].mask[k];
                     end
                     e = {1'b1, 1'b0, 1'(v >> 1), 1'(v), 2'(v), 1'b0, m};
                  end else if (t == RUN) begin
                     held_mask = q[0].mask;
                     held_pass = (q[0].mask == 4'd0);
                     e = {4'b0100, 2'b00, held_pass, held_mask};
                     void'(q.pop_front());
                  end
               end
               check("outputs", g, {busy_l, done_l, ga, gb, vec_l, pass_l, mask_l}, e);
            end
         end
      end
   end

   initial begin
      wait (lane[0].fin && lane[1].fin);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: stimulus did not complete, %0d checks so far", n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sequencer for a 2-input logic gate cell (NOR, AND, etc.). On a start request it drives all four input vectors {a,b} = 00, 01, 10, 11 into the gate in turn, waits a programmable settle time, samples the gate output and compares it with a 4-bit expected truth table. It reports a per-vector fail mask and a pass flag. It sits between a bench- or system-level control master and one gate instance, replacing the hand-written stimulus sequences in per-gate testbenches.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: extra cycles each vector is held before sampling. Legal range 0..255. Counter width is max(1, $clog2(SETTLE_CYCLES+1)).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; accepted only in IDLE.
- truth  in  4  expected gate output per vector index; bit i = expected y for {a,b} = i. Captured at start acceptance.
- gate_a  out  1  drives gate input a (= vec_idx[1] while running).
- gate_b  out  1  drives gate input b (= vec_idx[0] while running).
- gate_y  in  1  gate output under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  1 when the last completed sweep had no mismatches.
- fail_mask  out  4  bit i set when vector i mismatched.
- vec_idx  out  2  current vector index.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE:
  - gate_a = gate_b = 0, busy = 0.
  - On start = 1: capture truth into truth_q, clear fail_mask and pass, set vec_idx = 0, cnt = 0, go to APPLY.
- APPLY:
  - busy = 1; {gate_a, gate_b} = vec_idx.
  - Each edge with cnt < SETTLE_CYCLES: cnt increments.
  - At the edge with cnt == SETTLE_CYCLES: sample gate_y. If gate_y != truth_q[vec_idx], set fail_mask[vec_idx].
  - After that sample: if vec_idx == 3, go to DONE; otherwise increment vec_idx and set cnt = 0.
- DONE:
  - Lasts exactly one cycle: done = 1, busy = 0, gate_a = gate_b = 0.
  - pass = (fail_mask == 0), including the final sample.
  - Next edge: IDLE.
- Ignored inputs:
  - start in APPLY or DONE has no effect; it is not queued.
  - truth changes after capture have no effect on a run in progress.
- pass and fail_mask hold their values from DONE until the next accepted start.
- fail_mask bits update live during APPLY and are only sticky-set within a run.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state = IDLE, gate_a = 0, gate_b = 0, busy = 0, done = 0, pass = 0, fail_mask = 0, vec_idx = 0, cnt = 0, truth_q = 0.
- Let E0 be the edge that accepts start and S = SETTLE_CYCLES.
  - Vector k is driven from E0 + k(S+1) and sampled at edge E0 + (k+1)(S+1).
  - Each vector is held for S+1 cycles.
- busy rises after E0 and falls after E0 + 4(S+1).
- done is high for exactly the cycle following E0 + 4(S+1).
- Start-to-done latency is 4(S+1) cycles. Minimum start-to-start spacing is 4(S+1)+2 edges, because start is accepted in IDLE only.
- gate_y is treated as combinational from gate_a/gate_b. The S+1-cycle hold covers any registered gate latency up to S cycles.
- Reset asserted mid-run: the run is aborted, done is not produced, and every output returns to its reset value. After rst_n rises the block waits in IDLE for a new start.
- vec_idx wraps only via the transition to DONE; it never increments past 3.

## Test plan
- NOR gate model, S = 2, truth = 4'b0001, start pulse → gate vectors 00, 01, 10, 11 each held 3 cycles; done pulse 12 cycles after E0; pass = 1, fail_mask = 0.
- AND gate model, truth = 4'b0001 (NOR) → fail_mask = 4'b1001, pass = 0, done still at 4(S+1).
- start held high, or re-pulsed during APPLY and during the DONE cycle → only one run, one done pulse; the second sweep starts only on a start seen in IDLE.
- rst_n pulsed low while vec_idx = 2 → all outputs reach reset values immediately, no done pulse. A new start then completes a full sweep with correct results.
- S = 0, truth = 4'b1000, AND model → each vector held 1 cycle; done 4 cycles after E0; pass = 1.
- Back-to-back runs: first run fails (fail_mask = 4'b0010), second run uses a correct model → fail_mask clears at the second start; second done gives pass = 1, fail_mask = 0.
